// File: rtl/lot_occupancy.sv
// Parking-lot occupancy tracker: decodes entry/exit beam sequences from two
// debounced sensors and keeps a saturating 2-digit BCD count against CAPACITY.
module lot_occupancy #(
  parameter int CAPACITY = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a,
  input  logic       b,
  output logic [7:0] occupancy,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse,
  output logic       seq_err
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;

  localparam logic [7:0] CAP_BCD = {4'(CAPACITY / 10), 4'(CAPACITY % 10)};

  state_t     state_q, state_d;
  logic [1:0] ab;
  logic       entry_done, exit_done;
  logic [7:0] occ_q, occ_d;
  logic       full_q, full_d, empty_q, empty_d;
  logic       enter_q, enter_d, exit_q, exit_d, reject_q, reject_d;

  assign ab = {a, b};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Every transition not listed as a legal step or back-out is a two-bit jump.
  always_comb begin
    state_d    = state_q;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = EN1;
        2'b01:   state_d = EX1;
        2'b11:   state_d = ERR;
        default: state_d = IDLE;
      endcase
      EN1: case (ab)
        2'b11:   state_d = EN2;
        2'b00:   state_d = IDLE;
        2'b01:   state_d = ERR;
        default: state_d = EN1;
      endcase
      EN2: case (ab)
        2'b01:   state_d = EN3;
        2'b10:   state_d = EN1;
        2'b00:   state_d = ERR;
        default: state_d = EN2;
      endcase
      EN3: case (ab)
        2'b00:   begin state_d = IDLE; entry_done = 1'b1; end
        2'b11:   state_d = EN2;
        2'b10:   state_d = ERR;
        default: state_d = EN3;
      endcase
      EX1: case (ab)
        2'b11:   state_d = EX2;
        2'b00:   state_d = IDLE;
        2'b10:   state_d = ERR;
        default: state_d = EX1;
      endcase
      EX2: case (ab)
        2'b10:   state_d = EX3;
        2'b01:   state_d = EX1;
        2'b00:   state_d = ERR;
        default: state_d = EX2;
      endcase
      EX3: case (ab)
        2'b00:   begin state_d = IDLE; exit_done = 1'b1; end
        2'b11:   state_d = EX2;
        2'b01:   state_d = ERR;
        default: state_d = EX3;
      endcase
      ERR:     if (ab == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d    = occ_q;
    enter_d  = 1'b0;
    exit_d   = 1'b0;
    reject_d = 1'b0;
    if (entry_done) begin
      if (occ_q < CAP_BCD) begin
        occ_d   = bcd_inc(occ_q);
        enter_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (exit_done) begin
      if (occ_q != 8'h00) begin
        occ_d  = bcd_dec(occ_q);
        exit_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
    // Flags track the next count so they land on the same edge as occupancy.
    full_d  = (occ_d == CAP_BCD);
    empty_d = (occ_d == 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      occ_q    <= 8'h00;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      enter_q  <= enter_d;
      exit_q   <= exit_d;
      reject_q <= reject_d;
    end
  end

  assign occupancy    = occ_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign enter_pulse  = enter_q;
  assign exit_pulse   = exit_q;
  assign reject_pulse = reject_q;
  assign seq_err      = (state_q == ERR);

endmodule

// File: tb/tb_lot_occupancy.sv
// Directed bench: a default-capacity and a CAPACITY=3 instance share the sensor
// inputs; expected counts come from an integer model converted to BCD.
module tb_lot_occupancy;
  logic clk = 1'b0, reset_n = 1'b0, a = 1'b0, b = 1'b0;
  logic [7:0] occ_h, occ_s;
  logic full_h, empty_h, ent_h, ext_h, rej_h, err_h;
  logic full_s, empty_s, ent_s, ext_s, rej_s, err_s;
  int n_tests = 0, n_fail = 0;
  int cnt_h;

  always #5 clk = ~clk;

  lot_occupancy dut_h (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .occupancy(occ_h),
    .full(full_h), .empty(empty_h), .enter_pulse(ent_h), .exit_pulse(ext_h),
    .reject_pulse(rej_h), .seq_err(err_h));

  lot_occupancy #(.CAPACITY(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .occupancy(occ_s),
    .full(full_s), .empty(empty_s), .enter_pulse(ent_s), .exit_pulse(ext_s),
    .reject_pulse(rej_s), .seq_err(err_s));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Inputs change on negedge; each held value is sampled by n rising edges.
  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_entry(input int n);
    hold(2'b10, n); hold(2'b11, n); hold(2'b01, n); hold(2'b00, 1);
  endtask

  task automatic do_exit(input int n);
    hold(2'b01, n); hold(2'b11, n); hold(2'b10, n); hold(2'b00, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_occ",   occ_h, 8'h00);
    chk("rst_empty", {7'd0, empty_h}, 8'd1);
    chk("rst_full",  {7'd0, full_h}, 8'd0);
    chk("rst_puls",  {5'd0, ent_h, ext_h, rej_h}, 8'd0);
    chk("rst_err",   {7'd0, err_h}, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // first entry, each level held 3 clocks
    do_entry(3);
    chk("e1_pulse", {7'd0, ent_h}, 8'd1);
    chk("e1_occ",   occ_h, 8'h01);
    chk("e1_empty", {7'd0, empty_h}, 8'd0);
    hold(2'b00, 1);
    chk("e1_pulse_off", {7'd0, ent_h}, 8'd0);

    // CAPACITY=3 fills, then rejects
    do_entry(2); do_entry(2);
    chk("s3_occ",  occ_s, 8'h03);
    chk("s3_full", {7'd0, full_s}, 8'd1);
    chk("h3_full", {7'd0, full_h}, 8'd0);
    do_entry(2);
    chk("s4_rej",   {7'd0, rej_s}, 8'd1);
    chk("s4_ent",   {7'd0, ent_s}, 8'd0);
    chk("s4_occ",   occ_s, 8'h03);
    chk("h4_ent",   {7'd0, ent_h}, 8'd1);
    chk("h4_rej",   {7'd0, rej_h}, 8'd0);
    chk("h4_occ",   occ_h, 8'h04);

    cnt_h = 4;
    while (cnt_h < 20) begin
      do_entry(2);
      cnt_h++;
      chk("up_occ", occ_h, to_bcd(cnt_h));
    end

    do_exit(2);
    cnt_h--;
    chk("x_pulse", {7'd0, ext_h}, 8'd1);
    chk("x_occ",   occ_h, 8'h19);
    chk("xs_occ",  occ_s, 8'h02);
    chk("xs_full", {7'd0, full_s}, 8'd0);
    hold(2'b00, 1);
    chk("x_pulse_off", {7'd0, ext_h}, 8'd0);

    repeat (19) begin
      do_entry(2);
      cnt_h++;
      chk("up2_occ", occ_h, to_bcd(cnt_h));
    end
    chk("up2_final", occ_h, 8'h38);

    // exit while empty
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_exit(2);
    chk("xe_rej",   {7'd0, rej_h}, 8'd1);
    chk("xe_pulse", {7'd0, ext_h}, 8'd0);
    chk("xe_occ",   occ_h, 8'h00);
    chk("xe_empty", {7'd0, empty_h}, 8'd1);

    // back-out leaves no trace, FSM idles
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 1);
    chk("bo_puls", {5'd0, ent_h, ext_h, rej_h}, 8'd0);
    chk("bo_occ",  occ_h, 8'h00);
    hold(2'b00, 1);
    do_entry(2);
    chk("bo_then_entry", occ_h, 8'h01);

    // illegal double-bit jump
    hold(2'b11, 3);
    chk("err_set", {7'd0, err_h}, 8'd1);
    hold(2'b10, 2);
    chk("err_hold", {7'd0, err_h}, 8'd1);
    hold(2'b00, 1);
    chk("err_clr", {7'd0, err_h}, 8'd0);
    chk("err_occ", occ_h, 8'h01);
    chk("err_puls", {5'd0, ent_h, ext_h, rej_h}, 8'd0);

    // asynchronous reset in EN2
    hold(2'b10, 2); hold(2'b11, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_occ",   occ_h, 8'h00);
    chk("ar_empty", {7'd0, empty_h}, 8'd1);
    chk("ar_full",  {7'd0, full_s}, 8'd0);
    chk("ar_err",   {7'd0, err_h}, 8'd0);
    {a, b} = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_entry(2);
    chk("ar_entry", occ_h, 8'h01);
    chk("ar_epul",  {7'd0, ent_h}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lot_occupancy.md
Name: lot_occupancy

Overview:
- Consumes the two debounced beam-sensor levels (a = outer, b = inner) from the debounce stage.
- Decodes complete car entry/exit sequences and maintains a saturating 2-digit BCD occupancy count against a capacity limit.
- Occupancy feeds the bcd_decoder/disp_mux display path directly.
- Replaces the separate detector+counter pair with one block that adds full/empty status and sequence-error reporting.

Parameters:
- CAPACITY, 99, lot capacity as a decimal integer. Legal range 1..99; occupancy never exceeds it.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- a  input  1  debounced outer sensor, 1 = beam blocked; synchronous to clk
- b  input  1  debounced inner sensor, 1 = beam blocked; synchronous to clk
- occupancy  output  8  BCD count, [7:4] tens, [3:0] units, registered
- full  output  1  high while occupancy == CAPACITY
- empty  output  1  high while occupancy == 0
- enter_pulse  output  1  one-cycle pulse on each completed entry sequence
- exit_pulse  output  1  one-cycle pulse on each completed exit sequence
- reject_pulse  output  1  one-cycle pulse when an entry completes while full, or an exit completes while empty
- seq_err  output  1  high while FSM is in ERR

Behaviour:
- Reset (reset_n low, asynchronous): FSM to IDLE; occupancy 8'h00; empty 1; full 0; all pulses 0; seq_err 0.
  - Release is synchronous to clk; deassertion is pre-synchronized upstream.
- Inputs are sampled each clk as {a,b}.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR.
- IDLE:
  - 10 -> EN1; 01 -> EX1; 00 stays.
  - 11 -> ERR.
- EN1 (10):
  - 11 -> EN2; 00 -> IDLE (car backed out, no count); 10 stays.
  - 01 -> ERR.
- EN2 (11):
  - 01 -> EN3; 10 -> EN1 (back-out); 11 stays.
  - 00 -> ERR.
- EN3 (01):
  - 00 -> IDLE and entry complete; 11 -> EN2; 01 stays.
  - 10 -> ERR.
- EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped (01, 11, 10); EX3 with 00 -> IDLE and exit complete.
- ERR:
  - seq_err = 1.
  - Stays until {a,b} == 00, then -> IDLE. No count change.
  - Any double-bit change in a single sample also enters ERR.
- Entry complete:
  - If occupancy < CAPACITY: BCD increment, enter_pulse = 1.
  - Else: occupancy holds, reject_pulse = 1, enter_pulse = 0.
- Exit complete:
  - If occupancy > 0: BCD decrement, exit_pulse = 1.
  - Else: occupancy holds, reject_pulse = 1, exit_pulse = 0.
- Latency: occupancy, flags and pulses update on the same clk edge on which the FSM returns to IDLE, i.e. one clk after the 00 sample is presented.
- BCD arithmetic:
  - Units 9 + 1 -> 0 with carry into tens (e.g. 8'h19 -> 8'h20).
  - Units 0 - 1 -> 9 with borrow (e.g. 8'h20 -> 8'h19).
  - Both digits always hold 0..9.
- full and empty are registered alongside occupancy; they are never both 1 (CAPACITY >= 1).
- Entry and exit cannot complete in the same cycle; only one FSM exists.
- Reset mid-sequence: partial sequence is discarded and the count returns to 0.

Test Plan:
- Reset, then {a,b} = 10, 11, 01, 00 (each held 3 clks) -> enter_pulse one cycle; occupancy 8'h01; empty 0.
- From occupancy 8'h20, exit sequence 01, 11, 10, 00 -> exit_pulse; occupancy 8'h19. Then 19 entries -> 8'h38 via correct 8'h29 -> 8'h30 carry.
- CAPACITY = 3: four entries -> occupancy 8'h03; full 1 after the third; fourth gives reject_pulse with no enter_pulse.
- From empty, exit sequence -> reject_pulse; occupancy stays 8'h00; empty stays 1.
- Back-out: 10, 11, 10, 00 -> no pulses, occupancy unchanged, FSM in IDLE.
- Illegal 00 -> 11 jump -> seq_err 1 until 00 is sampled; count unchanged. Assert reset_n low mid-entry (at EN2) -> all outputs immediately at reset values.
